// File: rtl/memwb.sv
// memwb: memory/writeback stage; runs the data-memory req/ack access and drives the register-file write port.
module memwb #(
    parameter int RW      = 16,
    parameter int REGNO   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_submit,
    output logic             o_ready,
    input  logic [RW-1:0]    i_addr,
    input  logic [RW-1:0]    i_data,
    input  logic [REGNO-1:0] i_reg_ie,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    input  logic             i_mem_width,
    output logic [REGNO-1:0] o_reg_ie,
    output logic [RW-1:0]    o_reg_data,
    output logic             o_mem_req,
    output logic [RW-1:0]    o_mem_addr,
    output logic [RW-1:0]    o_mem_data,
    output logic             o_mem_we,
    output logic [1:0]       o_mem_sel,
    input  logic             i_mem_ack,
    input  logic [RW-1:0]    i_mem_rdata,
    input  logic             i_mem_fault,
    output logic             o_mem_exception
);
    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    // counter holds cycles already spent in REQ, so the last allowed cycle is TIMEOUT-1
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [REGNO-1:0] mask;
    logic [RW-1:0]    wb_data;
    logic [RW-1:0]    rd_fmt;
    logic             pass;
    logic             timed_out;
    assign pass      = state == IDLE && i_submit && !i_mem_access;
    assign o_ready   = (state == IDLE && !(i_submit && i_mem_access)) || state == WB;
    assign o_reg_ie  = pass ? i_reg_ie : state == WB ? mask : '0;
    assign o_reg_data = pass ? i_data : state == WB ? wb_data : '0;
    assign timed_out = TIMEOUT != 0 && cnt == TLIM;
    assign rd_fmt    = o_mem_sel == 2'b11 ? i_mem_rdata
                     : {{(RW-8){1'b0}}, o_mem_sel[1] ? i_mem_rdata[RW-1 -: 8] : i_mem_rdata[7:0]};
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            mask            <= '0;
            wb_data         <= '0;
            o_mem_req       <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_data      <= '0;
            o_mem_we        <= 1'b0;
            o_mem_sel       <= 2'b00;
            o_mem_exception <= 1'b0;
        end else begin
            o_mem_exception <= 1'b0;
            case (state)
                IDLE: if (i_submit && i_mem_access) begin
                    state      <= REQ;
                    o_mem_req  <= 1'b1;
                    o_mem_addr <= i_addr;
                    o_mem_data <= i_mem_width ? {(RW/8){i_data[7:0]}} : i_data;
                    o_mem_we   <= i_mem_we;
                    o_mem_sel  <= i_mem_width ? (i_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                    mask       <= i_reg_ie;
                    cnt        <= '0;
                end
                REQ: if (i_mem_fault || timed_out) begin
                    state           <= IDLE;
                    o_mem_req       <= 1'b0;
                    o_mem_we        <= 1'b0;
                    o_mem_exception <= 1'b1;
                end else if (i_mem_ack) begin
                    state     <= o_mem_we ? IDLE : WB;
                    o_mem_req <= 1'b0;
                    o_mem_we  <= 1'b0;
                    wb_data   <= rd_fmt;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
